// File: rtl/sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sequencer
// Description : Two-cycle-per-instruction control sequencer. Fetches an
//               opcode byte from the program ROM, then executes it while
//               the following ROM byte supplies the immediate or jump target.
//               Generates register load strobes, bus-assert enables and
//               drives the shared data bus for immediates.
// Revision    : 1.0 - initial release
// ============================================================================
module sequencer (
  input  logic       clkBar,
  input  logic       resetBar,
  input  logic [7:0] romData,
  input  logic [7:0] xreg,
  inout  wire  [7:0] dbus,
  output logic [7:0] pc,
  output logic       loadA,
  output logic       loadB,
  output logic       loadX,
  output logic       loadQ,
  output logic       assertBarA,
  output logic       assertBarX,
  output logic       halted
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] EXEC    = 2'd1;
  localparam logic [1:0] HALT    = 2'd2;

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_JXZ  = 2'b10;
  localparam logic [1:0] OP_HLT  = 2'b11;

  localparam logic [1:0] SRC_IMM = 2'b00;
  localparam logic [1:0] SRC_A   = 2'b01;
  localparam logic [1:0] SRC_X   = 2'b10;

  localparam logic [1:0] DST_A   = 2'b00;
  localparam logic [1:0] DST_B   = 2'b01;
  localparam logic [1:0] DST_X   = 2'b10;
  localparam logic [1:0] DST_Q   = 2'b11;

  logic [1:0] state;
  logic [1:0] state_next;
  logic [7:0] ir;
  logic [7:0] ir_next;
  logic [7:0] pc_next;
  logic [7:0] pc_inc;
  logic [1:0] op;
  logic [1:0] src;
  logic [1:0] dst;
  logic       drive_bus;
  logic       do_load;
  logic       unused_ir_bits;

  assign op             = ir[7:6];
  assign src            = ir[5:4];
  assign dst            = ir[3:2];
  assign unused_ir_bits = ^ir[1:0];

  // 8-bit add wraps naturally, so FF+1 lands on 00.
  assign pc_inc = pc + 8'd1;

  // Immediates come straight off the ROM byte at the current pc.
  assign dbus = drive_bus ? romData : 8'hzz;

  // State, program counter and instruction register update.
  always_ff @(posedge clkBar) begin
    if (!resetBar) begin
      state <= FETCH;
      pc    <= 8'h00;
      ir    <= 8'h00;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
    end
  end

  // Next-state, next-pc and instruction capture.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    case (state)
      FETCH: begin
        ir_next    = romData;
        pc_next    = pc_inc;
        state_next = (romData[7:6] == OP_HLT) ? HALT : EXEC;
      end
      EXEC: begin
        state_next = FETCH;
        case (op)
          OP_MOV:  pc_next = (src == SRC_IMM) ? pc_inc : pc;
          OP_JMP:  pc_next = romData;
          OP_JXZ:  pc_next = (xreg == 8'h00) ? romData : pc_inc;
          default: pc_next = pc;
        endcase
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Strobes decode from state and ir only, forced inactive during reset.
  always_comb begin
    loadA      = 1'b0;
    loadB      = 1'b0;
    loadX      = 1'b0;
    loadQ      = 1'b0;
    assertBarA = 1'b1;
    assertBarX = 1'b1;
    drive_bus  = 1'b0;
    do_load    = 1'b0;
    halted     = resetBar && (state == HALT);
    if (resetBar && (state == EXEC) && (op == OP_MOV)) begin
      case (src)
        SRC_IMM: begin
          drive_bus = 1'b1;
          do_load   = 1'b1;
        end
        SRC_A: begin
          assertBarA = 1'b0;
          do_load    = 1'b1;
        end
        SRC_X: begin
          assertBarX = 1'b0;
          do_load    = 1'b1;
        end
        default: begin
          do_load = 1'b0;
        end
      endcase
    end
    if (do_load) begin
      case (dst)
        DST_A:   loadA = 1'b1;
        DST_B:   loadB = 1'b1;
        DST_X:   loadX = 1'b1;
        DST_Q:   loadQ = 1'b1;
        default: loadA = 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/sequencer.md
SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 SHALL have port clkBar  input  1  single clock; all sequencer state updates on the rising edge of clkBar, and downstream registers latch on the falling edge.
REQ-002 SHALL have port resetBar  input  1  reset, synchronous and active-low, sampled on the rising edge of clkBar.
REQ-003 SHALL have port romData  input  8  program ROM byte at address pc.
REQ-004 SHALL have port xreg  input  8  current X register contents, used for the conditional jump.
REQ-005 SHALL have port dbus  inout  8  shared data bus; driven only when asserting an immediate, else high-Z.
REQ-006 SHALL have port pc  output  8  program counter and ROM address.
REQ-007 SHALL have ports loadA, loadB, loadX, loadQ  output  1 each  active-high register load strobes.
REQ-008 SHALL have ports assertBarA, assertBarX  output  1 each  active-low bus-assert enables for A and X.
REQ-009 SHALL have port halted  output  1  high while in HALT.

Function
REQ-010 SHALL hold an 8-bit instruction register ir and a 3-state FSM: FETCH, EXEC, HALT.
REQ-011 SHALL decode ir[7:6] as op: 00 MOV, 01 JMP, 10 JXZ, 11 HLT.
REQ-012 SHALL decode ir[5:4] as src: 00 IMM, 01 A, 10 X, 11 reserved; SHALL decode ir[3:2] as dst: 00 A, 01 B, 10 X, 11 Q; SHALL ignore ir[1:0].
REQ-013 In FETCH, SHALL load ir <= romData and pc <= pc+1, and SHALL go to HALT if romData[7:6]=11, else to EXEC.
REQ-014 In FETCH, SHALL keep all strobes inactive and dbus high-Z.
REQ-015 In EXEC with MOV and src IMM, SHALL drive dbus=romData, pulse the dst load for the cycle, and set pc <= pc+1.
REQ-016 In EXEC with MOV and src A or X, SHALL drive the matching assertBar low, pulse the dst load, leave dbus undriven by this block, and leave pc unchanged.
REQ-017 In EXEC with MOV and src reserved, SHALL behave as a NOP: no strobes, pc unchanged.
REQ-018 In EXEC with JMP, SHALL set pc <= romData with no strobes.
REQ-019 In EXEC with JXZ, SHALL set pc <= romData when xreg==0, else pc <= pc+1, with no strobes.
REQ-020 EXEC SHALL always return to FETCH; every instruction is 2 cycles, immediate/target byte included.
REQ-021 HALT SHALL be absorbing until reset: pc and ir frozen, strobes inactive, halted=1.
REQ-022 Strobes and assertBar SHALL be combinational from state and ir only, and stable across the whole clkBar period in which the downstream falling-edge latch occurs.
REQ-023 pc arithmetic SHALL be modulo 256 (8'hFF+1 = 8'h00, including immediate fetch at FF).
REQ-024 At most one load strobe and at most one of {assertBarA low, assertBarX low, dbus driven} SHALL be active in any cycle.

Reset
REQ-025 With resetBar low at a rising clkBar edge: state <= FETCH, pc <= 8'h00, ir <= 8'h00, regardless of current state (including mid-EXEC or HALT).
REQ-026 While resetBar is low, all load strobes SHALL be 0, both assertBar SHALL be 1, dbus SHALL be high-Z, and halted SHALL be 0.
REQ-027 The first FETCH after release SHALL read address 00.

Verification
REQ-028 ROM {00:00 (MOV A,IMM), 01:5A} -> cycle 2: dbus=5A, loadA=1, all other strobes 0; pc=02 after.
REQ-029 ROM {00:14 (MOV A<-A? no: src A, dst B), ...} -> EXEC: assertBarA=0, loadB=1, dbus not driven by this block, pc=01.
REQ-030 ROM {00:80 (JXZ), 01:10} with xreg=00 -> pc=10 after EXEC; with xreg=03 -> pc=02.
REQ-031 ROM {00:40 (JMP), 01:FE, FE:C0} -> pc 00,01,FE,FF; halted=1 from the cycle after FETCH at FE, pc frozen at FF.
REQ-032 pc=FF, ROM {FF:08 (MOV X,IMM)}, ROM[00]=33 -> loadX=1, dbus=33, pc wraps to 01.
REQ-033 resetBar low during EXEC of MOV IMM -> strobes drop immediately, pc=00 and state FETCH after the edge; halted clears when reset is asserted in HALT.
